// File: rtl/fpu_pkg.sv
// Shared types and constants for the sequential FP divider.
// Constant helpers return 64-bit words; callers truncate to their own W.
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIVIDE,
        ROUND,
        DONE
    } state_e;

    localparam int FLG_W  = 5;
    localparam int FLG_NX = 0;
    localparam int FLG_UF = 1;
    localparam int FLG_OF = 2;
    localparam int FLG_DZ = 3;
    localparam int FLG_NV = 4;

    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [63:0] inf_word(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
        return inf_word(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpu_div_iter.sv
// Restoring significand divider: one quotient bit per cycle, MAN_W+3 cycles after start.
// Latency: done is high during the last iteration cycle; results are stable until the next start.
// Backpressure: none; the owner only pulses start when idle.
module fpu_div_iter #(
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MAN_W+1:0] dividend,
    input  logic [MAN_W:0]   divisor,
    output logic             done,
    output logic [MAN_W+1:0] quotient,
    output logic [MAN_W+1:0] remainder
);

    localparam int RW = MAN_W + 2;
    localparam int CW = $clog2(MAN_W + 3);

    logic [RW-1:0]    rem_q, rem_d;
    logic [MAN_W:0]   dvs_q, dvs_d;
    logic [RW-1:0]    quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             act_q, act_d;
    logic [RW:0]      diff;
    logic             ge;
    logic [RW-1:0]    rem_sel;

    always_comb begin
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        diff    = {1'b0, rem_q} - {2'b00, dvs_q};
        ge      = !diff[RW];
        rem_sel = ge ? diff[RW-1:0] : rem_q;
        if (start) begin
            rem_d = dividend;
            dvs_d = divisor;
            quo_d = '0;
            cnt_d = CW'(MAN_W + 2);
            act_d = 1'b1;
        end else if (act_q) begin
            // Remainder stays below the divisor, so its top bit is free for the shift.
            rem_d = {rem_sel[RW-2:0], 1'b0};
            // The integer quotient bit is always 1 and falls off the top.
            quo_d = {quo_q[RW-2:0], ge};
            if (cnt_q == '0) begin
                act_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end

    assign done      = act_q && (cnt_q == '0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/fpu_div_seq.sv
// Sequential IEEE-754 divider with RNE rounding, flush-to-zero and exception flags.
// Latency: out_valid MAN_W+6 cycles after accept (2 for special operands).
// Backpressure: one operation in flight; result and flags hold until out_ready.
module fpu_div_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   float_num1,
    input  logic [EXP_W+MAN_W:0]   float_num2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   div_result,
    output logic [FLG_W-1:0]       flags,
    output logic                   busy
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW2 = EXP_W + 2;
    localparam logic [W-1:0]   QNAN   = W'(qnan_word(EXP_W, MAN_W));
    localparam logic [W-1:0]   INF    = W'(inf_word(EXP_W, MAN_W));
    localparam logic [EW2-1:0] BIAS_E = EW2'(bias_of(EXP_W));
    localparam logic [EW2-1:0] E_MAX  = EW2'((1 << EXP_W) - 1);

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic [EW2-1:0]     e_q, e_d;
    logic [W-1:0]       res_q, res_d;
    logic [FLG_W-1:0]   flg_q, flg_d;

    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_frac, b_frac;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, res_sgn;
    logic [MAN_W:0]     m1, m2;
    logic               adj;
    logic [MAN_W+1:0]   dividend;
    logic [EW2-1:0]     e_calc;

    logic               iter_start, iter_done;
    logic [MAN_W+1:0]   quo, rem;
    logic               g_bit, r_bit, s_bit, inc, carry, ovf, unf;
    logic [MAN_W-1:0]   frac_r;
    logic [EW2-1:0]     e_r;

    fpu_div_iter #(.MAN_W(MAN_W)) u_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (iter_start),
        .dividend  (dividend),
        .divisor   (m2),
        .done      (iter_done),
        .quotient  (quo),
        .remainder (rem)
    );

    // Unpack and classify; subnormals (exp == 0) are treated as zero.
    always_comb begin
        a_exp    = a_q[W-2:MAN_W];
        b_exp    = b_q[W-2:MAN_W];
        a_frac   = a_q[MAN_W-1:0];
        b_frac   = b_q[MAN_W-1:0];
        a_zero   = (a_exp == '0);
        b_zero   = (b_exp == '0);
        a_inf    = (&a_exp) && (a_frac == '0);
        b_inf    = (&b_exp) && (b_frac == '0);
        a_nan    = (&a_exp) && (a_frac != '0);
        b_nan    = (&b_exp) && (b_frac != '0);
        res_sgn  = a_q[W-1] ^ b_q[W-1];
        m1       = {1'b1, a_frac};
        m2       = {1'b1, b_frac};
        adj      = (m1 < m2);
        dividend = adj ? {m1, 1'b0} : {1'b0, m1};
        e_calc   = {2'b00, a_exp} - {2'b00, b_exp} + BIAS_E - {{(EW2-1){1'b0}}, adj};
    end

    always_comb begin
        g_bit           = quo[1];
        r_bit           = quo[0];
        s_bit           = |rem;
        inc             = g_bit && (r_bit || s_bit || quo[2]);
        {carry, frac_r} = {1'b0, quo[MAN_W+1:2]} + {{MAN_W{1'b0}}, inc};
        e_r             = e_q + {{(EW2-1){1'b0}}, carry};
        ovf             = ($signed(e_r) >= $signed(E_MAX));
        unf             = e_r[EW2-1] || (e_r == '0);
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        e_d        = e_q;
        res_d      = res_q;
        flg_d      = flg_q;
        iter_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = float_num1;
                    b_d     = float_num2;
                    state_d = PREP;
                end
            end
            PREP: begin
                flg_d   = '0;
                state_d = DONE;
                if (a_nan || b_nan) begin
                    res_d = QNAN;
                end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                    res_d         = QNAN;
                    flg_d[FLG_NV] = 1'b1;
                end else if (a_inf) begin
                    res_d = {res_sgn, INF[W-2:0]};
                end else if (b_zero) begin
                    res_d         = {res_sgn, INF[W-2:0]};
                    flg_d[FLG_DZ] = 1'b1;
                end else if (b_inf || a_zero) begin
                    res_d = {res_sgn, {(W-1){1'b0}}};
                end else begin
                    e_d        = e_calc;
                    iter_start = 1'b1;
                    state_d    = DIVIDE;
                end
            end
            DIVIDE: begin
                if (iter_done) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                flg_d   = '0;
                state_d = DONE;
                if (ovf) begin
                    res_d         = {res_sgn, INF[W-2:0]};
                    flg_d[FLG_OF] = 1'b1;
                    flg_d[FLG_NX] = 1'b1;
                end else if (unf) begin
                    res_d         = {res_sgn, {(W-1){1'b0}}};
                    flg_d[FLG_UF] = 1'b1;
                    flg_d[FLG_NX] = 1'b1;
                end else begin
                    res_d         = {res_sgn, e_r[EXP_W-1:0], frac_r};
                    flg_d[FLG_NX] = g_bit || r_bit || s_bit;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            e_q     <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            e_q     <= e_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign div_result = res_q;
    assign flags      = flg_q;

endmodule
